// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32IM control unit: sequences FETCH/DECODE/EXEC/MEM/MULDIV/WB, handshakes with
// instruction/data memory and the mul/div unit, and raises precise traps.
module multicycle_control_fsm #(
  parameter bit          ENABLE_M    = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_instr,
  input  logic        i_imem_ack,
  input  logic        i_dmem_ack,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_muldiv_done,
  output logic        o_imem_req,
  output logic        o_dmem_req,
  output logic        o_mem_we,
  output logic        o_ir_write,
  output logic        o_alu_src,
  output logic        o_mem_to_reg,
  output logic        o_is_csr,
  output logic        o_csr_en,
  output logic [1:0]  o_alu_op,
  output logic [2:0]  o_branch_type,
  output logic [1:0]  o_pc_sel,
  output logic        o_muldiv_start,
  output logic        o_reg_write,
  output logic        o_pc_write,
  output logic        o_trap_enter,
  output logic        o_trap_exit,
  output logic [31:0] o_exception_code,
  output logic        o_instr_retired
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef enum logic [2:0] {
    StFetch, StDecode, StExec, StMem, StMulDiv, StWb, StTrap, StMret
  } state_e;

  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       is_csr;
    logic       csr_en;
    logic [1:0] alu_op;
    logic [2:0] br_type;
    logic [1:0] size;
    logic       load;
    logic       store;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       muldiv;
  } ctrl_t;

  state_e            r_state, w_state_d;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_ir;
  ctrl_t             r_ctrl, w_dec;
  logic [31:0]       r_exc_code, w_exc_d;
  logic              r_md_started;
  logic              w_illegal, w_ecall, w_ebreak, w_mret;
  logic              w_timeout, w_misaligned;
  logic [6:0]        w_opcode, w_funct7;
  logic [2:0]        w_funct3;

  assign w_opcode  = r_ir[6:0];
  assign w_funct3  = r_ir[14:12];
  assign w_funct7  = r_ir[31:25];
  assign w_timeout = (r_cnt == CNT_W'(MEM_TIMEOUT - 1));
  assign w_misaligned = (r_ctrl.size == 2'b10 && i_addr_lo != 2'b00) ||
                        (r_ctrl.size == 2'b01 && i_addr_lo[0]);

  always_comb begin
    w_dec      = '0;
    w_illegal  = 1'b0;
    w_ecall    = 1'b0;
    w_ebreak   = 1'b0;
    w_mret     = 1'b0;
    w_dec.size = w_funct3[1:0];
    case (w_opcode)
      OpLoad: begin
        w_dec.alu_src    = 1'b1;
        w_dec.mem_to_reg = 1'b1;
        w_dec.load       = 1'b1;
        w_illegal        = (w_funct3 == 3'b011) || (w_funct3[2:1] == 2'b11);
      end
      OpStore: begin
        w_dec.alu_src = 1'b1;
        w_dec.store   = 1'b1;
        w_illegal     = w_funct3[2] || (w_funct3[1:0] == 2'b11);
      end
      OpImm: begin
        w_dec.alu_src = 1'b1;
        w_dec.alu_op  = 2'b10;
        w_illegal     = (w_funct3 == 3'b001 && w_funct7 != 7'b0000000) ||
                        (w_funct3 == 3'b101 && w_funct7 != 7'b0000000 && w_funct7 != 7'b0100000);
      end
      OpReg: begin
        w_dec.alu_op = 2'b10;
        if (w_funct7 == 7'b0000001) begin
          w_dec.muldiv = 1'b1;
          w_illegal    = !ENABLE_M;
        end else begin
          w_illegal = !(w_funct7 == 7'b0000000 ||
                        (w_funct7 == 7'b0100000 && (w_funct3 == 3'b000 || w_funct3 == 3'b101)));
        end
      end
      OpLui: begin
        w_dec.alu_src = 1'b1;
        w_dec.alu_op  = 2'b11;
      end
      OpAuipc: w_dec.alu_src = 1'b1;
      OpJal:   w_dec.jal = 1'b1;
      OpJalr: begin
        w_dec.alu_src = 1'b1;
        w_dec.jalr    = 1'b1;
        w_illegal     = (w_funct3 != 3'b000);
      end
      OpBranch: begin
        w_dec.alu_op = 2'b01;
        w_dec.branch = 1'b1;
        case (w_funct3)
          3'b000:  w_dec.br_type = 3'b000;
          3'b001:  w_dec.br_type = 3'b001;
          3'b100:  w_dec.br_type = 3'b010;
          3'b101:  w_dec.br_type = 3'b011;
          3'b110:  w_dec.br_type = 3'b100;
          3'b111:  w_dec.br_type = 3'b101;
          default: w_illegal = 1'b1;
        endcase
      end
      OpFence: ;
      OpSystem: begin
        if (r_ir == 32'h0000_0073) begin
          w_ecall = 1'b1;
        end else if (r_ir == 32'h0010_0073) begin
          w_ebreak = 1'b1;
        end else if (r_ir == 32'h3020_0073) begin
          w_mret = 1'b1;
        end else if (w_funct3 != 3'b000 && w_funct3 != 3'b100) begin
          w_dec.is_csr = 1'b1;
          // csrrs/csrrc with a zero source read the CSR without writing it
          w_dec.csr_en = (w_funct3[1:0] == 2'b01) || (r_ir[19:15] != 5'd0);
        end else begin
          w_illegal = 1'b1;
        end
      end
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_state_d        = r_state;
    w_exc_d          = r_exc_code;
    o_imem_req       = 1'b0;
    o_dmem_req       = 1'b0;
    o_mem_we         = 1'b0;
    o_ir_write       = 1'b0;
    o_alu_src        = 1'b0;
    o_mem_to_reg     = 1'b0;
    o_is_csr         = 1'b0;
    o_csr_en         = 1'b0;
    o_alu_op         = 2'b00;
    o_branch_type    = 3'b000;
    o_pc_sel         = 2'b00;
    o_muldiv_start   = 1'b0;
    o_reg_write      = 1'b0;
    o_pc_write       = 1'b0;
    o_trap_enter     = 1'b0;
    o_trap_exit      = 1'b0;
    o_exception_code = 32'd0;
    o_instr_retired  = 1'b0;
    case (r_state)
      StFetch: begin
        o_imem_req = 1'b1;
        if (i_imem_ack) begin
          o_ir_write = 1'b1;
          w_state_d  = StDecode;
        end else if (w_timeout) begin
          w_state_d = StTrap;
          w_exc_d   = 32'd1;
        end
      end
      StDecode: begin
        w_state_d = StExec;
        if (w_illegal) begin
          w_state_d = StTrap;
          w_exc_d   = 32'd2;
        end else if (w_ecall) begin
          w_state_d = StTrap;
          w_exc_d   = 32'd11;
        end else if (w_ebreak) begin
          w_state_d = StTrap;
          w_exc_d   = 32'd3;
        end else if (w_mret) begin
          w_state_d = StMret;
        end
      end
      StExec: begin
        if (r_ctrl.load || r_ctrl.store) begin
          if (w_misaligned) begin
            w_state_d = StTrap;
            w_exc_d   = r_ctrl.store ? 32'd6 : 32'd4;
          end else begin
            w_state_d = StMem;
          end
        end else if (r_ctrl.muldiv) begin
          w_state_d = StMulDiv;
        end else begin
          w_state_d = StWb;
        end
      end
      StMem: begin
        o_dmem_req = 1'b1;
        o_mem_we   = r_ctrl.store;
        // an ack arriving on the last allowed cycle still completes the access
        if (i_dmem_ack) begin
          w_state_d = StWb;
        end else if (w_timeout) begin
          w_state_d = StTrap;
          w_exc_d   = r_ctrl.store ? 32'd7 : 32'd5;
        end
      end
      StMulDiv: begin
        o_muldiv_start = !r_md_started;
        if (i_muldiv_done) w_state_d = StWb;
      end
      StWb: begin
        o_pc_write      = 1'b1;
        o_instr_retired = 1'b1;
        o_reg_write     = !(r_ctrl.store || r_ctrl.branch);
        o_pc_sel        = (r_ctrl.branch || r_ctrl.jal) ? 2'b01 :
                          r_ctrl.jalr ? 2'b10 : 2'b00;
        w_state_d       = StFetch;
      end
      StTrap: begin
        o_trap_enter     = 1'b1;
        o_exception_code = r_exc_code;
        o_pc_write       = 1'b1;
        o_pc_sel         = 2'b11;
        w_state_d        = StFetch;
      end
      StMret: begin
        o_trap_exit     = 1'b1;
        o_pc_write      = 1'b1;
        o_pc_sel        = 2'b11;
        o_instr_retired = 1'b1;
        w_state_d       = StFetch;
      end
      default: w_state_d = StFetch;
    endcase

    if (r_state == StDecode) begin
      o_alu_src     = w_dec.alu_src;
      o_mem_to_reg  = w_dec.mem_to_reg;
      o_is_csr      = w_dec.is_csr;
      o_csr_en      = w_dec.csr_en;
      o_alu_op      = w_dec.alu_op;
      o_branch_type = w_dec.br_type;
    end else if (r_state == StExec || r_state == StMem || r_state == StMulDiv ||
                 r_state == StWb) begin
      o_alu_src     = r_ctrl.alu_src;
      o_mem_to_reg  = r_ctrl.mem_to_reg;
      o_is_csr      = r_ctrl.is_csr;
      o_csr_en      = r_ctrl.csr_en;
      o_alu_op      = r_ctrl.alu_op;
      o_branch_type = r_ctrl.br_type;
    end

    // Reset silences every output in the same cycle, not just from the next edge
    if (i_rst) begin
      w_state_d        = StFetch;
      o_imem_req       = 1'b0;
      o_dmem_req       = 1'b0;
      o_mem_we         = 1'b0;
      o_ir_write       = 1'b0;
      o_alu_src        = 1'b0;
      o_mem_to_reg     = 1'b0;
      o_is_csr         = 1'b0;
      o_csr_en         = 1'b0;
      o_alu_op         = 2'b00;
      o_branch_type    = 3'b000;
      o_pc_sel         = 2'b00;
      o_muldiv_start   = 1'b0;
      o_reg_write      = 1'b0;
      o_pc_write       = 1'b0;
      o_trap_enter     = 1'b0;
      o_trap_exit      = 1'b0;
      o_exception_code = 32'd0;
      o_instr_retired  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StFetch;
      r_cnt        <= '0;
      r_ir         <= '0;
      r_ctrl       <= '0;
      r_exc_code   <= '0;
      r_md_started <= 1'b0;
    end else begin
      r_state <= w_state_d;
      // Counts consecutive wait cycles; any state entry clears it
      r_cnt   <= (w_state_d == r_state && (r_state == StFetch || r_state == StMem)) ?
                 r_cnt + 1'b1 : '0;
      if (r_state == StFetch && i_imem_ack) r_ir <= i_instr;
      if (r_state == StDecode) r_ctrl <= w_dec;
      r_exc_code   <= w_exc_d;
      r_md_started <= (r_state == StMulDiv);
    end
  end

endmodule
